// File: rtl/fringe_run_ctrl.sv
// Run sequencer behind the host Avalon-MM slave: command/status, argIn/argOut and cycle-count registers.
// Optional watchdog is built when FRINGE_CTRL_WATCHDOG_EN is defined.

module fringe_argout_lane (
  input  logic        clock,
  input  logic        reset,
  input  logic        cap,
  input  logic [31:0] d,
  output logic [31:0] q
);
  always_ff @(posedge clock or posedge reset)
    if (reset)    q <= '0;
    else if (cap) q <= d;
endmodule

module fringe_run_ctrl #(
  parameter int NUM_ARG_INS    = 1,
  parameter int NUM_ARG_OUTS   = 1,
  parameter int ADDR_W         = 7,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [ADDR_W-1:0]           io_S_AVALON_address,
  input  logic                        io_S_AVALON_chipselect,
  input  logic                        io_S_AVALON_write,
  input  logic                        io_S_AVALON_read,
  input  logic [31:0]                 io_S_AVALON_writedata,
  output logic [31:0]                 io_S_AVALON_readdata,
  output logic                        io_accel_enable,
  output logic                        io_accel_reset,
  input  logic                        io_accel_done,
  output logic [32*NUM_ARG_INS-1:0]   io_argIns,
  input  logic [32*NUM_ARG_OUTS-1:0]  io_argOuts,
  input  logic [NUM_ARG_OUTS-1:0]     io_argOuts_valid
);
  localparam int AI_BASE = 2;
  localparam int AO_BASE = AI_BASE + NUM_ARG_INS;
  localparam int CC_ADDR = AO_BASE + NUM_ARG_OUTS;

  if (NUM_ARG_INS < 1 || NUM_ARG_OUTS < 1 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("fringe_run_ctrl: NUM_ARG_INS, NUM_ARG_OUTS and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_DONE} state_e;

  typedef struct packed {
    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } avl_req_t;

  avl_req_t req;
  assign req = '{wr:   io_S_AVALON_chipselect & io_S_AVALON_write,
                 rd:   io_S_AVALON_chipselect & io_S_AVALON_read,
                 addr: io_S_AVALON_address,
                 data: io_S_AVALON_writedata};

  state_e state_q, state_d;
  logic   busy, cmd_ok, start, wd_hit, timeout, cmd_q;
  logic [31:0] cyc_q, rd_mux, rd_addr;
  logic [NUM_ARG_INS-1:0][31:0]  arg_in;
  logic [NUM_ARG_OUTS-1:0][31:0] arg_out, ao_in;

  assign busy    = (state_q == S_LAUNCH) || (state_q == S_RUN);
  // Command writes only land while idle or done; LAUNCH/RUN ignore them.
  assign cmd_ok  = req.wr && (req.addr == ADDR_W'(0)) && !busy;
  assign start   = cmd_ok && req.data[0];

`ifdef FRINGE_CTRL_WATCHDOG_EN
  logic [31:0] wdog_q;
  logic        timeout_q;
  // A done on the limit edge wins, so the timeout only fires without done.
  assign wd_hit  = (state_q == S_RUN) && !io_accel_done &&
                   (wdog_q == 32'(TIMEOUT_CYCLES - 1));
  assign timeout = timeout_q;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else if (start) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == S_RUN) wdog_q    <= wdog_q + 32'd1;
      if (wd_hit)           timeout_q <= 1'b1;
    end
`else
  assign wd_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset)
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_RUN;
      S_RUN:    if (io_accel_done || wd_hit) state_d = S_DONE;
      S_DONE:   if (cmd_ok) state_d = start ? S_LAUNCH : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign io_accel_enable = (state_q == S_RUN);
  assign io_accel_reset  = (state_q == S_LAUNCH);

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cmd_q <= 1'b0;
      cyc_q <= '0;
    end else begin
      if (cmd_ok) cmd_q <= req.data[0];
      if (start)                                   cyc_q <= '0;
      else if (state_q == S_RUN && cyc_q != '1)    cyc_q <= cyc_q + 32'd1;
    end

  always_ff @(posedge clock or posedge reset)
    if (reset) arg_in <= '0;
    else
      for (int i = 0; i < NUM_ARG_INS; i++)
        if (req.wr && !busy && req.addr == ADDR_W'(AI_BASE + i)) arg_in[i] <= req.data;

  assign io_argIns = arg_in;
  assign ao_in     = io_argOuts;

  for (genvar g = 0; g < NUM_ARG_OUTS; g++) begin : g_ao
    fringe_argout_lane u_lane (
      .clock (clock),
      .reset (reset),
      .cap   (io_argOuts_valid[g] && state_q == S_RUN),
      .d     (ao_in[g]),
      .q     (arg_out[g])
    );
  end

  assign rd_addr = 32'(req.addr);

  always_comb begin
    rd_mux = '0;
    if (rd_addr == 32'd0) rd_mux = {31'b0, cmd_q};
    if (rd_addr == 32'd1) rd_mux = {29'b0, timeout, busy, state_q == S_DONE};
    for (int i = 0; i < NUM_ARG_INS; i++)
      if (rd_addr == 32'(AI_BASE + i)) rd_mux = arg_in[i];
    for (int i = 0; i < NUM_ARG_OUTS; i++)
      if (rd_addr == 32'(AO_BASE + i)) rd_mux = arg_out[i];
    if (rd_addr == 32'(CC_ADDR)) rd_mux = cyc_q;
  end

  // Registered read port: sampled values are pre-edge, so read+write returns old data.
  always_ff @(posedge clock or posedge reset)
    if (reset)       io_S_AVALON_readdata <= '0;
    else if (req.rd) io_S_AVALON_readdata <= rd_mux;

endmodule

// File: tb/tb_fringe_run_ctrl.sv
// Self-checking bench for fringe_run_ctrl: vector table, directed run sequences, randomized traffic vs. a model.
module tb_fringe_run_ctrl;
  localparam int TMO = 16;
`ifdef FRINGE_CTRL_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic        clock = 0, reset = 0;
  logic [6:0]  addr = '0;
  logic        cs = 0, wr = 0, rd = 0;
  logic [31:0] wdata = '0, rdata;
  logic        enable, accel_reset, done = 0;
  logic [31:0] arg_ins, arg_outs = '0;
  logic        valid = 0;

  int n_pass = 0, n_tot = 0;

  fringe_run_ctrl #(.NUM_ARG_INS(1), .NUM_ARG_OUTS(1), .ADDR_W(7), .TIMEOUT_CYCLES(TMO)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .io_S_AVALON_address    (addr),
    .io_S_AVALON_chipselect (cs),
    .io_S_AVALON_write      (wr),
    .io_S_AVALON_read       (rd),
    .io_S_AVALON_writedata  (wdata),
    .io_S_AVALON_readdata   (rdata),
    .io_accel_enable        (enable),
    .io_accel_reset         (accel_reset),
    .io_accel_done          (done),
    .io_argIns              (arg_ins),
    .io_argOuts             (arg_outs),
    .io_argOuts_valid       (valid)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic avl_write(input logic [6:0] a, input logic [31:0] d);
    cs = 1; wr = 1; addr = a; wdata = d;
    tick;
    cs = 0; wr = 0;
  endtask

  task automatic avl_read(input logic [6:0] a, output logic [31:0] d);
    cs = 1; rd = 1; addr = a;
    tick;
    cs = 0; rd = 0;
    d = rdata;
  endtask

  task automatic do_reset;
    reset = 1;
    tick; tick;
    reset = 0;
    tick;
  endtask

  // ---------------- behavioural model for the random phase ----------------
  bit          m_launch, m_run, m_done, m_to, m_cmd;
  logic [31:0] m_argin, m_argout, m_rd;
  longint      m_cyc;
  int          m_wd;

  function automatic logic [31:0] model_read(input logic [6:0] a);
    case (a)
      7'd0:    return {31'b0, m_cmd};
      7'd1:    return {29'b0, m_to, m_launch | m_run, m_done};
      7'd2:    return m_argin;
      7'd3:    return m_argout;
      7'd4:    return m_cyc[31:0];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge;
    bit busy, cmdw;
    busy = m_launch | m_run;
    cmdw = cs && wr && addr == 7'd0 && !busy;
    if (cs && rd) m_rd = model_read(addr);
    if (cs && wr && addr == 7'd2 && !busy) m_argin = wdata;
    if (m_run && valid) m_argout = arg_outs;
    if (m_launch) begin
      m_launch = 0; m_run = 1;
    end else if (m_run) begin
      if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
      m_wd++;
      if (done) begin m_run = 0; m_done = 1; end
      else if (WD_ON && m_wd == TMO) begin m_run = 0; m_done = 1; m_to = 1; end
    end else if (cmdw) begin
      m_cmd = wdata[0]; m_done = 0;
      if (wdata[0]) begin m_launch = 1; m_cyc = 0; m_to = 0; m_wd = 0; end
    end
  endtask

  typedef struct {
    bit          is_wr;
    logic [6:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t        vt[$];
    logic [31:0] r;

    vt.push_back('{0, 7'd0,   0, 32'h0});
    vt.push_back('{0, 7'd1,   0, 32'h0});
    vt.push_back('{0, 7'd2,   0, 32'h0});
    vt.push_back('{0, 7'd3,   0, 32'h0});
    vt.push_back('{0, 7'd4,   0, 32'h0});
    vt.push_back('{0, 7'd5,   0, 32'h0});
    vt.push_back('{0, 7'd127, 0, 32'h0});
    vt.push_back('{1, 7'd2,   32'h4, 0});
    vt.push_back('{0, 7'd2,   0, 32'h4});
    vt.push_back('{1, 7'd1,   32'hFF, 0});
    vt.push_back('{0, 7'd1,   0, 32'h0});
    vt.push_back('{1, 7'd3,   32'hAB, 0});
    vt.push_back('{0, 7'd3,   0, 32'h0});
    vt.push_back('{1, 7'd4,   32'h5, 0});
    vt.push_back('{0, 7'd4,   0, 32'h0});
    vt.push_back('{1, 7'd100, 32'h1, 0});
    vt.push_back('{0, 7'd100, 0, 32'h0});
    vt.push_back('{0, 7'd1,   0, 32'h0});

    // reset state
    reset = 1;
    #1;
    chk("rst_enable", {31'b0, enable}, 0);
    chk("rst_accel_reset", {31'b0, accel_reset}, 0);
    chk("rst_readdata", rdata, 0);
    chk("rst_argins", arg_ins, 0);
    tick; tick;
    reset = 0;
    tick;

    foreach (vt[i]) begin
      if (vt[i].is_wr) avl_write(vt[i].a, vt[i].d);
      else begin
        avl_read(vt[i].a, r);
        chk($sformatf("vec%0d_rd_a%0d", i, vt[i].a), r, vt[i].exp);
      end
    end
    chk("argins_after_wr", arg_ins, 32'h4);

    // simultaneous read+write returns old data
    cs = 1; rd = 1; wr = 1; addr = 7'd2; wdata = 32'h55;
    tick;
    cs = 0; rd = 0; wr = 0;
    chk("rw_same_old", rdata, 32'h4);
    avl_read(7'd2, r);
    chk("rw_same_new", r, 32'h55);
    avl_write(7'd2, 32'h4);

    // launch / run / done sequence
    avl_write(7'd0, 32'h1);
    chk("launch_accel_reset", {31'b0, accel_reset}, 1);
    chk("launch_enable", {31'b0, enable}, 0);
    tick;
    chk("run_accel_reset", {31'b0, accel_reset}, 0);
    chk("run_enable", {31'b0, enable}, 1);
    avl_write(7'd2, 32'h9);
    avl_write(7'd0, 32'h0);
    avl_read(7'd1, r);
    chk("run_status", r, 32'h2);
    avl_read(7'd2, r);
    chk("run_argin_protected", r, 32'h4);
    chk("run_argins_port", arg_ins, 32'h4);
    repeat (45) tick;
    done = 1; valid = 1; arg_outs = 32'h10;
    tick;
    done = 0; valid = 0;
    chk("done_enable_low", {31'b0, enable}, 0);
    avl_read(7'd1, r);
    chk("done_status", r, 32'h1);
    avl_read(7'd3, r);
    chk("done_argout", r, 32'h10);
    avl_read(7'd4, r);
    chk("done_cyc_count", r, 32'd50);
    valid = 1; arg_outs = 32'h77; done = 1;
    tick;
    valid = 0; done = 0;
    avl_read(7'd3, r);
    chk("argout_no_cap_outside_run", r, 32'h10);
    avl_read(7'd1, r);
    chk("done_ignored_in_done", r, 32'h1);
    avl_write(7'd0, 32'h0);
    avl_read(7'd1, r);
    chk("clear_status", r, 32'h0);
    avl_read(7'd0, r);
    chk("cmd_readback", r, 32'h0);

    // asynchronous reset mid-run
    avl_write(7'd0, 32'h1);
    tick;
    repeat (10) tick;
    chk("pre_rst_enable", {31'b0, enable}, 1);
    reset = 1;
    #1;
    chk("async_rst_enable", {31'b0, enable}, 0);
    tick;
    reset = 0;
    tick;
    chk("post_rst_argins", arg_ins, 0);
    for (int a = 0; a < 5; a++) begin
      avl_read(7'(a), r);
      chk($sformatf("post_rst_rd_a%0d", a), r, 0);
    end

`ifdef FRINGE_CTRL_WATCHDOG_EN
    avl_write(7'd0, 32'h1);
    tick;
    repeat (15) tick;
    chk("wd_enable_c16", {31'b0, enable}, 1);
    tick;
    chk("wd_enable_off", {31'b0, enable}, 0);
    avl_read(7'd1, r);
    chk("wd_status", r, 32'h5);
    avl_read(7'd4, r);
    chk("wd_cyc_count", r, 32'd16);
    avl_write(7'd0, 32'h1);
    tick;
    repeat (15) tick;
    done = 1;
    tick;
    done = 0;
    avl_read(7'd1, r);
    chk("wd_done_wins", r, 32'h1);
    avl_write(7'd0, 32'h0);
    avl_read(7'd1, r);
    chk("wd_clear", r, 32'h0);
`else
    avl_write(7'd0, 32'h1);
    tick;
    repeat (40) tick;
    chk("nowd_enable_held", {31'b0, enable}, 1);
    avl_read(7'd1, r);
    chk("nowd_status_busy", r, 32'h2);
    done = 1;
    tick;
    done = 0;
    avl_read(7'd1, r);
    chk("nowd_done_status", r, 32'h1);
    avl_read(7'd4, r);
    chk("nowd_cyc_count", r, 32'd42);
    avl_write(7'd0, 32'h0);
`endif

    // randomized traffic against the model
    do_reset;
    m_launch = 0; m_run = 0; m_done = 0; m_to = 0; m_cmd = 0;
    m_argin = 0; m_argout = 0; m_rd = 0; m_cyc = 0; m_wd = 0;
    for (int c = 0; c < 3000; c++) begin
      int op;
      op = int'($urandom_range(0, 9));
      cs = 0; wr = 0; rd = 0;
      addr  = 7'($urandom_range(0, 6));
      if ($urandom_range(0, 15) == 0) addr = 7'd127;
      wdata = $urandom;
      if      (op < 3)  begin cs = 1; rd = 1; end
      else if (op < 5)  begin cs = 1; wr = 1; end
      else if (op == 5) begin cs = 1; rd = 1; wr = 1; end
      else if (op == 6) begin wr = 1; rd = 1; end
      done     = ($urandom_range(0, 24) == 0);
      valid    = ($urandom_range(0, 3) == 0);
      arg_outs = $urandom;
      model_edge();
      tick;
      chk($sformatf("rnd%0d_readdata", c), rdata, m_rd);
      chk($sformatf("rnd%0d_enable", c), {31'b0, enable}, {31'b0, m_run});
      chk($sformatf("rnd%0d_accel_reset", c), {31'b0, accel_reset}, {31'b0, m_launch});
      chk($sformatf("rnd%0d_argins", c), arg_ins, m_argin);
    end
    cs = 0; wr = 0; rd = 0; done = 0; valid = 0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
